fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch controller that sequences the combinational-read instruction memory for the CPU core. It holds the program counter and drives the memory address. It registers each returned word into a single-entry output stage, then hands it to decode with a valid/ready handshake. It also applies jump/branch redirects from execute and guards the legal address window of the instruction store (words 0..26).

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- MAX_ADDR, 26, highest legal instruction word address
- START_ADDR, 0, PC value loaded at reset and on leaving IDLE
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  level; begins fetching from IDLE
- imem_addr  output  ADDR_WIDTH  address to instruction memory (combinational = pc)
- imem_data  input  DATA_WIDTH  instruction word from memory, valid same cycle as imem_addr
- instr_out  output  DATA_WIDTH  registered instruction to decode
- instr_pc  output  ADDR_WIDTH  address instr_out was fetched from
- instr_valid  output  1  instr_out/instr_pc hold a live instruction
- instr_ready  input  1  decode accepts instr_out this cycle
- redirect_valid  input  1  one-cycle jump/branch-taken pulse from execute
- redirect_addr  input  ADDR_WIDTH  redirect target word address
- fault  output  1  sticky out-of-range indication
- fetch_count  output  16  number of words captured since reset, wraps at 0xFFFF->0

## Operation
- States: IDLE, RUN, FAULT.
- IDLE: pc = START_ADDR, instr_valid = 0, no capture. start=1 -> RUN at next edge.
- RUN, fetch condition: fetch = !instr_valid || instr_ready.
  - On fetch: instr_out <= imem_data; instr_pc <= pc; instr_valid <= 1; pc <= pc+1; fetch_count <= fetch_count+1.
  - No fetch (valid && !ready): all output registers and pc hold; imem_addr stays stable.
- Redirect has priority over fetch in RUN, including while stalled.
  - pc <= redirect_addr; instr_valid <= 0 (flushes the held word); no capture that cycle; fetch_count unchanged.
  - If instr_ready=1 in the same cycle, the held word still counts as accepted by decode; it is then dropped from the stage.
- Range handling: see Configuration. pc arithmetic is modulo 2^ADDR_WIDTH. Comparison is unsigned.
- FAULT: instr_valid = 0, fault = 1, pc frozen. redirect_valid and start are ignored. Only reset exits.
- start deasserting in RUN has no effect. Only reset returns to IDLE.

## Timing
- Reset values: state IDLE, pc START_ADDR, imem_addr START_ADDR, instr_out 0, instr_pc 0, instr_valid 0, fault 0, fetch_count 0.
- Reset is asynchronous: mid-stall or mid-redirect, all state clears immediately. Nothing survives.
- start sampled at edge E0 -> RUN. First capture at E1. instr_valid high after E1, with instr_pc = START_ADDR.
- Throughput: one instruction per cycle while instr_ready=1.
- Redirect latency: redirect_valid at edge N clears valid and loads pc. Target word is captured at N+1, so instr_valid is high after N+1 with instr_pc = redirect_addr. Bubble: exactly one cycle.
- Back-to-back redirects: the last one wins. Each one flushes.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - In RUN, if pc > MAX_ADDR at an edge where a fetch would occur, enter FAULT instead of capturing. instr_valid <= 0 and fault <= 1 at that edge.
  - A redirect to an address > MAX_ADDR is accepted. It faults at the following fetch edge.
- FETCH_BOUNDS_CHECK_EN undefined:
  - fault is tied to 0 and FAULT is unreachable.
  - Next pc after MAX_ADDR is 0 (wrap).
  - A redirect_addr > MAX_ADDR loads 0.

## Test plan
- Reset, start=1 for one cycle, instr_ready=1, memory words 0..3 = A,B,C,D -> instr_out A,B,C,D on consecutive cycles; instr_pc 0,1,2,3; fetch_count 4.
- Stall: instr_ready=0 for 3 cycles while instr_pc=2 -> instr_out, instr_pc and imem_addr=3 all hold. Release -> word 3 follows next cycle with no duplication or loss.
- Redirect to 13 while stalled on instr_pc=5 -> valid drops for exactly one cycle, then instr_pc=13. Word 5 is never re-presented.
- Redirect at the same edge as instr_ready=1 -> one accept of the held word, then one bubble, then the target word.
- With FETCH_BOUNDS_CHECK_EN, run to pc=27 -> fault=1 and instr_valid=0 after the edge, fetch_count=27. Redirect ignored. Reset clears fault. Without the macro, pc=26 is followed by instr_pc=0.
- Assert reset asynchronously mid-cycle during a fetch -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/instruction-fetch controller with a one-entry output stage and redirect support.
// Ports: clk, reset (async, active-high), start (leave IDLE), imem_addr/imem_data (combinational
// instruction memory), instr_out/instr_pc/instr_valid/instr_ready (decode handshake),
// redirect_valid/redirect_addr (jump/branch from execute), fault (sticky out-of-range),
// fetch_count (words captured since reset, wraps).
// Build option FETCH_BOUNDS_CHECK_EN: fault on fetch from pc > MAX_ADDR instead of wrapping to 0.
module fetch_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_ADDR = 26,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  fault,
  output logic [15:0]           fetch_count
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDR);
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] pc, pc_inc, redir_pc;
  logic fetch, over;
  assign imem_addr = pc;
  assign fetch = !instr_valid || instr_ready;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign over = pc > MAX_A;
  assign pc_inc = pc + ADDR_WIDTH'(1);
  assign redir_pc = redirect_addr;
  assign fault = state == FAULT;
`else
  assign over = 1'b0;
  assign pc_inc = pc >= MAX_A ? '0 : pc + ADDR_WIDTH'(1);
  assign redir_pc = redirect_addr > MAX_A ? '0 : redirect_addr;
  assign fault = 1'b0;
`endif
  // IDLE is only reachable through reset, so pc is already START_A there.
  // FAULT has no transitions out: pc and the stage stay frozen until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= START_A;
      instr_out <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else if (state == IDLE) begin
      if (start) state <= RUN;
    end else if (state == RUN) begin
      if (redirect_valid) begin
        pc <= redir_pc;
        instr_valid <= 1'b0;
      end else if (fetch && over) begin
        state <= FAULT;
        instr_valid <= 1'b0;
      end else if (fetch) begin
        instr_out <= imem_data;
        instr_pc <= pc;
        instr_valid <= 1'b1;
        pc <= pc_inc;
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table, corner sequences and randomized model check of fetch_sequencer.
module tb_fetch_sequencer;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  localparam int MAX = 26;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, instr_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0, imem_addr, imem_data, instr_out, instr_pc;
  logic instr_valid, fault;
  logic [15:0] fetch_count;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  int m_st;
  bit m_v;
  logic [31:0] m_pc, m_out, m_ipc;
  logic [15:0] m_cnt;
  typedef struct {
    bit st, rdy, rv;
    logic [31:0] ra;
    bit ev;
    logic [31:0] eipc, eaddr;
    logic [15:0] ecnt;
    bit ef;
  } vec_t;
  vec_t tbl [17];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .fault(fault), .fetch_count(fetch_count)
  );

  assign imem_data = mem[imem_addr[7:0]];
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] target(logic [31:0] a);
    return (!B && a > MAX) ? 32'd0 : a;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_pc = 0; m_v = 0; m_out = 0; m_ipc = 0; m_cnt = 0;
  endfunction

  // Spec-level behaviour of one clock edge: 0 idle, 1 run, 2 fault.
  function automatic void model_edge();
    if (m_st == 0) begin
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      if (redirect_valid) begin
        m_pc = target(redirect_addr);
        m_v = 0;
      end else if (!m_v || instr_ready) begin
        if (B && m_pc > MAX) begin
          m_st = 2;
          m_v = 0;
        end else begin
          m_out = mem[m_pc[7:0]];
          m_ipc = m_pc;
          m_v = 1;
          m_cnt = m_cnt + 16'd1;
          m_pc = B ? m_pc + 1 : (m_pc + 1) % (MAX + 1);
        end
      end
    end
  endfunction

  task automatic check_all(string tag);
    chk({tag, " imem_addr"}, imem_addr, m_pc);
    chk({tag, " valid"}, instr_valid, m_v);
    chk({tag, " instr_pc"}, instr_pc, m_ipc);
    chk({tag, " instr_out"}, instr_out, m_out);
    chk({tag, " fault"}, fault, m_st == 2);
    chk({tag, " count"}, fetch_count, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    start = 0; instr_ready = 0; redirect_valid = 0; redirect_addr = 0;
    reset = 1;
    #2;
    model_reset();
    check_all("reset");
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    // {start, ready, redirect, raddr, exp valid, exp instr_pc, exp imem_addr, exp count, exp fault}
    tbl[0]  = '{1, 1, 0, 0,  0, 0,  0,  0, 0};
    tbl[1]  = '{0, 1, 0, 0,  1, 0,  1,  1, 0};
    tbl[2]  = '{0, 1, 0, 0,  1, 1,  2,  2, 0};
    tbl[3]  = '{0, 1, 0, 0,  1, 2,  3,  3, 0};
    tbl[4]  = '{0, 0, 0, 0,  1, 2,  3,  3, 0};
    tbl[5]  = '{0, 0, 0, 0,  1, 2,  3,  3, 0};
    tbl[6]  = '{0, 0, 0, 0,  1, 2,  3,  3, 0};
    tbl[7]  = '{0, 1, 0, 0,  1, 3,  4,  4, 0};
    tbl[8]  = '{0, 1, 0, 0,  1, 4,  5,  5, 0};
    tbl[9]  = '{0, 1, 0, 0,  1, 5,  6,  6, 0};
    tbl[10] = '{0, 0, 1, 13, 0, 5,  13, 6, 0};
    tbl[11] = '{0, 1, 0, 0,  1, 13, 14, 7, 0};
    tbl[12] = '{0, 1, 1, 20, 0, 13, 20, 7, 0};
    tbl[13] = '{0, 1, 0, 0,  1, 20, 21, 8, 0};
    tbl[14] = '{0, 1, 1, 40, 0, 20, B ? 40 : 0, 8, 0};
    tbl[15] = B ? '{0, 1, 0, 0, 0, 20, 40, 8, 1} : '{0, 1, 0, 0, 1, 0, 1, 9, 0};
    tbl[16] = B ? '{0, 1, 1, 3, 0, 20, 40, 8, 1} : '{0, 1, 1, 3, 0, 0, 3, 9, 0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].st; instr_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv; redirect_addr = tbl[i].ra;
      step();
      chk($sformatf("vec%0d valid", i), instr_valid, tbl[i].ev);
      chk($sformatf("vec%0d instr_pc", i), instr_pc, tbl[i].eipc);
      chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d count", i), fetch_count, tbl[i].ecnt);
      chk($sformatf("vec%0d fault", i), fault, tbl[i].ef);
      if (tbl[i].ev) chk($sformatf("vec%0d instr_out", i), instr_out, mem[tbl[i].eipc[7:0]]);
    end

    // Run off the end of the legal window.
    do_reset();
    start = 1; instr_ready = 1;
    step();
    start = 0;
    repeat (27) step();
    chk("edge count", fetch_count, 27);
    chk("edge instr_pc", instr_pc, 26);
    chk("edge imem_addr", imem_addr, B ? 27 : 0);
    step();
    check_all("edge+1");
    chk("edge+1 fault", fault, B);
    chk("edge+1 valid", instr_valid, !B);
    chk("edge+1 count", fetch_count, B ? 27 : 28);
    if (!B) chk("wrap instr_pc", instr_pc, 0);
    redirect_valid = 1; redirect_addr = 5;
    step();
    redirect_valid = 0;
    check_all("fault redirect");
    chk("fault redirect addr", imem_addr, B ? 27 : 5);
    do_reset();
    chk("fault cleared", fault, 0);

    // Asynchronous reset mid-cycle while streaming.
    start = 1; instr_ready = 1;
    step();
    start = 0;
    repeat (5) step();
    #2 reset = 1;
    #1;
    chk("async valid", instr_valid, 0);
    chk("async imem_addr", imem_addr, 0);
    chk("async instr_pc", instr_pc, 0);
    chk("async instr_out", instr_out, 0);
    chk("async count", fetch_count, 0);
    chk("async fault", fault, 0);
    #1 reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("post async");

    // Randomized run against the model, plus an accept scoreboard.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      start = $urandom_range(0, 3) == 0;
      instr_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 7) == 0;
      redirect_addr = $urandom_range(0, 40);
      if (instr_valid && instr_ready) chk("accept word", instr_out, mem[instr_pc[7:0]]);
      step();
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
